// File: rtl/booth_mult_r2_seq.sv
// Sequential radix-2 Booth multiplier (W-bit signed x W-bit signed -> 2W-bit signed).
// Define BOOTH_ONE_CYCLE_EN to fold the add/sub and shift into one EVAL cycle (fixed latency W).
module booth_mult_r2_seq #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [W-1:0]     i_mcand,
    input  logic [W-1:0]     i_mplier,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [2*W-1:0]   o_product
);

    localparam int unsigned CW = $clog2(W + 1);

`ifdef BOOTH_ONE_CYCLE_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EVAL  = 2'b01,
        DONE  = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EVAL  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [W:0]        a_q, a_d;
    logic [W-1:0]      q_q, q_d;
    logic              qm1_q, qm1_d;
    logic [W:0]        m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]    prod_q, prod_d;

    logic [1:0]        brc;
    logic [W:0]        addsub;
    logic [W:0]        sh_in;
    logic [W:0]        sh_a;
    logic [W-1:0]      sh_q;
    logic              sh_qm1;
    logic              do_shift;
    logic              load;
    logic              last;

    always_comb begin
        brc    = {q_q[0], qm1_q};
        // BRC 10 subtracts M, BRC 01 adds it; only meaningful when Q[0] != q_m1
        addsub = q_q[0] ? (a_q - m_q) : (a_q + m_q);
        last   = (cnt_q == CW'(1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        sh_in    = a_q;
        do_shift = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    load = 1'b1;
                end
            end
            EVAL: begin
                if (brc == 2'b01 || brc == 2'b10) begin
`ifdef BOOTH_ONE_CYCLE_EN
                    sh_in    = addsub;
                    do_shift = 1'b1;
`else
                    a_d     = addsub;
                    state_d = SHIFT;
`endif
                end else begin
                    do_shift = 1'b1;
                end
            end
`ifndef BOOTH_ONE_CYCLE_EN
            SHIFT: begin
                do_shift = 1'b1;
            end
`endif
            DONE: begin
                if (i_start) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Arithmetic right shift of {A,Q,q_m1}, A[W] replicated into the MSB
        sh_a   = {sh_in[W], sh_in[W:1]};
        sh_q   = {sh_in[0], q_q[W-1:1]};
        sh_qm1 = q_q[0];

        if (do_shift) begin
            a_d   = sh_a;
            q_d   = sh_q;
            qm1_d = sh_qm1;
            cnt_d = cnt_q - CW'(1);
            if (last) begin
                state_d = DONE;
                prod_d  = {sh_a[W-1:0], sh_q};
            end else begin
                state_d = EVAL;
            end
        end

        if (load) begin
            a_d     = '0;
            q_d     = i_mplier;
            qm1_d   = 1'b0;
            m_d     = {i_mcand[W-1], i_mcand};
            cnt_d   = CW'(W);
            state_d = EVAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        o_ready   = (state_q == IDLE) || (state_q == DONE);
`ifdef BOOTH_ONE_CYCLE_EN
        o_busy    = (state_q == EVAL);
`else
        o_busy    = (state_q == EVAL) || (state_q == SHIFT);
`endif
        o_done    = (state_q == DONE);
        o_product = prod_q;
    end

endmodule

// File: tb/tb_booth_mult_r2_seq.sv
// Self-checking bench for booth_mult_r2_seq (W=8); honours BOOTH_ONE_CYCLE_EN for latency.
module tb_booth_mult_r2_seq;

    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic [W-1:0]    i_mcand;
    logic [W-1:0]    i_mplier;
    logic            o_ready;
    logic            o_busy;
    logic            o_done;
    logic [2*W-1:0]  o_product;

    int              n_vec;
    int              n_err;
    int              cyc;
    logic [2*W-1:0]  prev_prod;
    logic            seen_done;

    booth_mult_r2_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_mcand   (i_mcand),
        .i_mplier  (i_mplier),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_product (o_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = $signed(a);
        pb = $signed(b);
        return 16'(pa * pb);
    endfunction

    // One extra cycle for every position where a multiplier bit differs from the bit below it
    function automatic int ref_lat(input logic [W-1:0] b);
        int   n;
        logic prev;
        n    = 0;
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (b[i] != prev) n++;
            prev = b[i];
        end
`ifdef BOOTH_ONE_CYCLE_EN
        return W;
`else
        return W + n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_op(input logic [W-1:0] mc, input logic [W-1:0] mp);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_start  = 1'b1;
        i_mcand  = mc;
        i_mplier = mp;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
        i_mcand  = W'($urandom);
        i_mplier = W'($urandom);
        cyc      = 0;
        check("busy_after_accept", 32'(o_busy), 32'd1);
        check("done_after_accept", 32'(o_done), 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [2*W-1:0] exp_prod, input int exp_lat);
        while (o_done !== 1'b1 && cyc < 100) begin
            tick();
            if (o_done !== 1'b1) check("product_hold", 32'(o_product), 32'(prev_prod));
        end
        check({tag, "_done_seen"}, 32'(o_done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_product"}, 32'(o_product), 32'(exp_prod));
        prev_prod = exp_prod;
    endtask

    task automatic finish_idle();
        tick();
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("idle_ready", 32'(o_ready), 32'd1);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_product", 32'(o_product), 32'(prev_prod));
    endtask

    initial begin
        logic [W-1:0] mc;
        logic [W-1:0] mp;
        int           lat;

        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        prev_prod = '0;
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_mcand   = '0;
        i_mplier  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_product", 32'(o_product), 32'd0);
        rst_n = 1'b1;
        tick();

        // 3 * 5: four add/sub steps
        start_op(8'd3, 8'd5);
`ifdef BOOTH_ONE_CYCLE_EN
        wait_done("3x5", 16'd15, 8);
`else
        wait_done("3x5", 16'd15, 12);
`endif
        finish_idle();

        start_op(8'h80, 8'h80);
        wait_done("m128xm128", 16'h4000, ref_lat(8'h80));
        finish_idle();

        start_op(8'h80, 8'h7F);
        wait_done("m128x127", 16'hC080, ref_lat(8'h7F));
        finish_idle();

        start_op(8'h5A, 8'h00);
        wait_done("mplier00", 16'd0, 8);
        finish_idle();

        start_op(8'd3, 8'h55);
`ifdef BOOTH_ONE_CYCLE_EN
        wait_done("mplier55", 16'd255, 8);
`else
        wait_done("mplier55", 16'd255, 16);
`endif
        finish_idle();

        // Back-to-back: second accept on the DONE edge, no IDLE in between
        start_op(8'hF9, 8'd3);
        wait_done("b2b_first", 16'hFFEB, ref_lat(8'd3));
        start_op(8'd6, 8'hFA);
        wait_done("b2b_second", 16'hFFDC, ref_lat(8'hFA));
        finish_idle();

        // i_start while busy must be ignored
        start_op(8'd100, 8'h55);
        repeat (3) tick();
        i_start  = 1'b1;
        i_mcand  = 8'h11;
        i_mplier = 8'h0F;
        repeat (2) tick();
        i_start  = 1'b0;
        wait_done("busy_ignore", 16'd8500, ref_lat(8'h55));
        finish_idle();

        // Asynchronous reset mid-operation
        start_op(8'd9, 8'h55);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_product", 32'(o_product), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_prod = '0;
        seen_done = 1'b0;
        repeat (20) begin
            tick();
            seen_done = seen_done | o_done;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_product_after", 32'(o_product), 32'd0);
        start_op(8'd5, 8'd6);
        wait_done("after_abort", 16'd30, ref_lat(8'd6));
        finish_idle();

        // Randomized operands, alternating idle gaps and back-to-back accepts
        for (int i = 0; i < 40; i++) begin
            mc  = W'($urandom);
            mp  = W'($urandom);
            lat = ref_lat(mp);
            start_op(mc, mp);
            wait_done("rand", ref_prod(mc, mp), lat);
            if (i % 3 == 0) finish_idle();
        end
        finish_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
